// File: rtl/seqdet_arb_pkg.sv
// Shared constants for the multi-channel 10101 sequence detector.
package seqdet_arb_pkg;

  // Detector state = length of the matched prefix of 1,0,1,0,1 (MSB first)
  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  localparam int PAT_LEN   = 5;
  localparam int CNT_W_DEF = 8;
  localparam int PTR_W     = 2;   // enough for up to 4 channels

endpackage

// File: rtl/seqdet_core.sv
// Combinational next-state / hit function of the 10101 detector.
// Shared by all channels; the caller muxes in the granted channel's context.
module seqdet_core
  import seqdet_arb_pkg::*;
(
  input  logic [2:0] state,
  input  logic       din,
  output logic [2:0] nxt,
  output logic       hit
);

  // Prefix-length transitions; after a full match the trailing 1 restarts at S1.
  always_comb begin
    nxt = S0;
    hit = 1'b0;
    case (state)
      S0: nxt = din ? S1 : S0;
      S1: nxt = din ? S1 : S2;
      S2: nxt = din ? S3 : S0;
      S3: nxt = din ? S1 : S4;
      S4: begin
        nxt = din ? S1 : S0;
        hit = din;
      end
      // Unused codes behave exactly like S0
      default: nxt = din ? S1 : S0;
    endcase
  end

endmodule

// File: rtl/seqdet_arb.sv
// Round-robin arbiter feeding NCH serial channels into one shared 10101
// detector. Each channel keeps its own saved context and saturating counter.
// Note: rst_n is active HIGH despite its name.
module seqdet_arb
  import seqdet_arb_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NCH-1:0]       ch_valid,
  input  logic [NCH-1:0]       ch_bit,
  input  logic [NCH-1:0]       ch_clr,
  output logic [NCH-1:0]       ch_ready,
  output logic [NCH-1:0]       match,
  output logic [NCH*CNT_W-1:0] match_cnt,
  output logic [2:0]           present_state
);

  logic [PTR_W-1:0]      rr_ptr, rr_nxt;
  logic                  gnt_vld;
  logic [2:0]            cur_ctx, core_nxt;
  logic                  cur_bit, core_hit;
  logic [NCH-1:0][2:0]   ctx;
  int                    idx;

  // Round-robin search upward from rr_ptr; also muxes the winner's context/bit.
  // Grants are suppressed while disabled or held in reset.
  always_comb begin
    ch_ready = '0;
    gnt_vld  = 1'b0;
    cur_ctx  = S0;
    cur_bit  = 1'b0;
    rr_nxt   = rr_ptr;
    idx      = 0;
    if (ena && !rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        for (int i = 0; i < NCH; i++) begin
          if (!gnt_vld && idx == i && ch_valid[i] && !ch_clr[i]) begin
            gnt_vld     = 1'b1;
            ch_ready[i] = 1'b1;
            cur_ctx     = ctx[i];
            cur_bit     = ch_bit[i];
            rr_nxt      = (i == NCH-1) ? '0 : PTR_W'(i + 1);
          end
        end
      end
    end
  end

  seqdet_core u_core (
    .state (cur_ctx),
    .din   (cur_bit),
    .nxt   (core_nxt),
    .hit   (core_hit)
  );

  // Pointer advances past the granted channel; debug state follows accepted beats.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rr_ptr        <= '0;
      present_state <= S0;
    end else if (gnt_vld) begin
      rr_ptr        <= rr_nxt;
      present_state <= core_nxt;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [2:0]       ctx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             m_q;

    // Per-channel context, saturating counter and match pulse. A clear never
    // coincides with a grant (clear blocks the grant), so no match can escape.
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        ctx_q <= S0;
        cnt_q <= '0;
        m_q   <= 1'b0;
      end else begin
        m_q <= 1'b0;
        if (ch_clr[i]) begin
          ctx_q <= S0;
          cnt_q <= '0;
        end else if (ch_ready[i]) begin
          ctx_q <= core_nxt;
          m_q   <= core_hit;
          if (core_hit && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign ctx[i]                     = ctx_q;
    assign match[i]                   = m_q;
    assign match_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_seqdet_arb.sv
// Randomized + directed bench for seqdet_arb with a history-based reference model.
module tb_seqdet_arb;
  import seqdet_arb_pkg::*;

  localparam int NCH   = 3;
  localparam int CNT_W = 2;
  localparam int OW    = 2*NCH + NCH*CNT_W + 3;

  logic                 clk, rst_n, ena;
  logic [NCH-1:0]       ch_valid, ch_bit, ch_clr, ch_ready, match;
  logic [NCH*CNT_W-1:0] match_cnt;
  logic [2:0]           present_state;

  seqdet_arb #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_clr(ch_clr),
    .ch_ready(ch_ready), .match(match), .match_cnt(match_cnt),
    .present_state(present_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: per-channel recent accepted bits since last match/clear
  int             rr;
  logic [4:0]     hbits [NCH];
  int             hlen  [NCH];
  int             mcnt  [NCH];
  logic [NCH-1:0] exp_ready, exp_match, obs_ready;
  logic [2:0]     exp_ps;

  // Longest suffix of the history that equals a prefix of 1,0,1,0,1
  function automatic int prefix_len(logic [4:0] hb, int hl);
    int best = 0;
    for (int k = 1; k <= PAT_LEN && k <= hl; k++) begin
      bit ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (hb[k-1-j] != ((j % 2 == 0) ? 1'b1 : 1'b0)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    logic [NCH*CNT_W-1:0] c = '0;
    for (int i = 0; i < NCH; i++) c[i*CNT_W +: CNT_W] = CNT_W'(mcnt[i]);
    return {exp_ready, exp_match, c, exp_ps};
  endfunction

  function automatic logic [OW-1:0] obs_vec();
    return {obs_ready, match, match_cnt, present_state};
  endfunction

  task automatic model_reset();
    rr = 0; exp_ps = 3'd0; exp_match = '0; exp_ready = '0;
    for (int i = 0; i < NCH; i++) begin hbits[i] = '0; hlen[i] = 0; mcnt[i] = 0; end
  endtask

  // Entered at posedge+1; drives one cycle, samples ready before the edge,
  // advances the model, returns at the following posedge+1.
  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                      input logic [NCH-1:0] c, input logic e);
    int g = -1;
    int k;
    ch_valid = v; ch_bit = b; ch_clr = c; ena = e;
    #4;
    obs_ready = ch_ready;
    if (e)
      for (int n = 0; n < NCH; n++) begin
        int id = (rr + n) % NCH;
        if (g < 0 && v[id] && !c[id]) g = id;
      end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    @(posedge clk); #1;
    exp_match = '0;
    for (int i = 0; i < NCH; i++)
      if (c[i]) begin hbits[i] = '0; hlen[i] = 0; mcnt[i] = 0; end
    if (g >= 0) begin
      hbits[g] = {hbits[g][3:0], b[g]};
      hlen[g]  = (hlen[g] < PAT_LEN) ? hlen[g] + 1 : PAT_LEN;
      k = prefix_len(hbits[g], hlen[g]);
      if (k == PAT_LEN) begin
        exp_match[g] = 1'b1;
        if (mcnt[g] < (1 << CNT_W) - 1) mcnt[g]++;
        hbits[g] = 5'b00001; hlen[g] = 1; exp_ps = 3'd1;
      end else exp_ps = 3'(k);
      rr = (g + 1) % NCH;
    end
  endtask

  task automatic do_reset();
    ch_valid = '0; ch_bit = '0; ch_clr = '0; ena = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ena = 1'b1; ch_valid = '1; ch_clr = '0; ch_bit = NCH'($urandom);
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({ch_ready, match, match_cnt, present_state} !== '0) begin
      failures++;
      $display("FAIL reset_state got %h want 0", {ch_ready, match, match_cnt, present_state});
    end
    do_reset();
  endtask

  // Channel 0 alone: 1,0,1,0,1 then one idle cycle
  task automatic test_single();
    logic [4:0] pat = 5'b10101;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      if (n < 5) step(3'b001, {2'b00, pat[4-n]}, '0, 1'b1);
      else       step('0, '0, '0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL single cyc%0d got %h want %h", n, obs_vec(), exp_vec());
      end
      checks++;
      if (match[0] !== (n == 4) || (n < 5 && obs_ready[0] !== 1'b1)) begin
        failures++; $display("FAIL single_pulse cyc%0d match=%b ready=%b", n, match, obs_ready);
      end
    end
    checks++;
    if (match_cnt[CNT_W-1:0] !== CNT_W'(1)) begin
      failures++; $display("FAIL single_cnt got %0d want 1", match_cnt[CNT_W-1:0]);
    end
  endtask

  // 101010101 -> matches after beats 5 and 9, ends in S1
  task automatic test_stream();
    logic [8:0] pat = 9'b101010101;
    do_reset();
    for (int n = 0; n < 9; n++) begin
      step(3'b001, {2'b00, pat[8-n]}, '0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL stream cyc%0d got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (match_cnt[CNT_W-1:0] !== CNT_W'(2) || present_state !== 3'b001 || match[0] !== 1'b1) begin
      failures++;
      $display("FAIL stream_end cnt=%0d ps=%b match=%b want 2/001/1",
               match_cnt[CNT_W-1:0], present_state, match[0]);
    end
  endtask

  // ch0 and ch1 both valid: strict alternation starting at ch0
  task automatic test_alternate();
    int acc0 = 0;
    logic [NCH-1:0] want;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      step(3'b011, {2'b00, (acc0 % 2 == 0)}, '0, 1'b1);
      if (exp_ready[0]) acc0++;
      want = (n % 2 == 0) ? NCH'(1) : NCH'(2);
      checks++;
      if (obs_vec() !== exp_vec() || obs_ready !== want) begin
        failures++;
        $display("FAIL alternate cyc%0d got %h want %h ready=%b", n, obs_vec(), exp_vec(), obs_ready);
      end
    end
    checks++;
    if (match_cnt[CNT_W-1:0] !== CNT_W'(1) || match_cnt[CNT_W +: CNT_W] !== '0) begin
      failures++; $display("FAIL alternate_cnt got %h want ch0=1 ch1=0", match_cnt);
    end
  endtask

  // ch1 produces five matches with a 2-bit counter -> saturates at 3
  task automatic test_saturate();
    logic [4:0] pat = 5'b10101;
    do_reset();
    for (int n = 0; n < 25; n++) begin
      step(3'b010, {1'b0, pat[4 - (n % 5)], 1'b0}, '0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL saturate cyc%0d got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (match_cnt[CNT_W +: CNT_W] !== 2'd3) begin
      failures++; $display("FAIL saturate_cnt got %0d want 3", match_cnt[CNT_W +: CNT_W]);
    end
  endtask

  // ch0 parked at S4 with count 1, then cleared while offering a 1
  task automatic test_clear();
    logic [7:0] pat = 8'b10101010;
    do_reset();
    for (int n = 0; n < 8; n++) step(3'b001, {2'b00, pat[7-n]}, '0, 1'b1);
    step(3'b001, 3'b001, 3'b001, 1'b1);
    checks++;
    if (obs_ready[0] !== 1'b0 || match[0] !== 1'b0 || match_cnt[CNT_W-1:0] !== '0) begin
      failures++;
      $display("FAIL clear ready=%b match=%b cnt=%0d want 0/0/0", obs_ready[0], match[0], match_cnt[CNT_W-1:0]);
    end
    step(3'b001, 3'b001, '0, 1'b1);
    checks++;
    if (match[0] !== 1'b0 || present_state !== 3'b001 || obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL clear_ctx got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  // Async reset mid-cycle with ch0 at S3 and a nonzero count
  task automatic test_async_reset();
    logic [6:0] pat = 7'b1010101;
    do_reset();
    for (int n = 0; n < 7; n++) step(3'b001, {2'b00, pat[6-n]}, '0, 1'b1);
    ch_valid = 3'b001; ch_bit = 3'b000;
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if ({ch_ready, match, match_cnt, present_state} !== '0) begin
      failures++;
      $display("FAIL async_reset got %h want 0", {ch_ready, match, match_cnt, present_state});
    end
    ch_valid = '0;
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step(3'b001, 3'b000, '0, 1'b1);
    step(3'b001, 3'b001, '0, 1'b1);
    checks++;
    if (match !== '0 || present_state !== 3'b001 || obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL async_restart got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  // Random traffic, clears and enable drops against the model
  task automatic test_random();
    logic [NCH-1:0] v, b, c;
    logic e;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v = NCH'($urandom);
      b = NCH'($urandom);
      c = ($urandom_range(0, 9) == 0) ? NCH'(1 << $urandom_range(0, NCH-1)) : '0;
      e = ($urandom_range(0, 9) != 0);
      step(v, b, c, e);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random cyc%0d got %h want %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; ch_valid = '0; ch_bit = '0; ch_clr = '0;
    model_reset();
    test_reset();
    test_single();
    test_stream();
    test_alternate();
    test_saturate();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
